fetch_issue_ctrl: RTL and testbench
===================================

// Module: fetch_issue_ctrl
// PURPOSE
//  Sequences instruction fetch and issue for the 5-bit-opcode 32-bit core. Owns the PC, drives the
//  instruction-memory request, resolves J at fetch, and holds BEQ until EX resolves it.
//  Interlocks RAW hazards with a per-register scoreboard, which removes hand-inserted NOPs.
//  Sits between instruction memory and the decode stage; halts on the END word.
// PARAMETERS
//  WB_LAT    3   cycles from issue until a written register is readable (1..7)
//  PC_RESET  0   PC value after reset
//  STALL_W   16  width of the hazard-stall counter (saturating)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request; held high until imem_valid
//  imem_addr    out  32  word address = PC
//  imem_rdata   in   32  fetched word; valid when imem_valid=1
//  imem_valid   in   1   rdata valid this cycle (may coincide with first req cycle)
//  ex_ready     in   1   decode/EX can accept an instruction this cycle
//  br_done      in   1   one-cycle pulse: the outstanding BEQ is resolved
//  br_taken     in   1   qualified by br_done
//  br_target    in   32  qualified by br_done & br_taken
//  if_valid     out  1   one-cycle issue strobe
//  if_instr     out  32  issued word; NOP (0xF8000000) when if_valid=0
//  if_pc        out  32  PC of the issued word
//  halted       out  1   END (0xFFFFFFFF) reached; sticky until reset
//  stall_cnt    out  STALL_W  count of ISSUE cycles lost to scoreboard hazards
// BEHAVIOUR
//  Reset (async): pc=PC_RESET, state=FETCH, imem_req=0, if_valid=0, if_instr=NOP, if_pc=0,
//   halted=0, stall_cnt=0, all scoreboard counters=0.
//   An imem_valid arriving after reset for a fetch abandoned by reset is ignored.
//  Fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], jaddr={5'b0,[26:0]}.
//  Op classes: R-type {0 ADD,1 SUB,4 MLT,17 CMP} read rs,rt and write rd.
//   Immediate {2 ADDI,3 SUBI} read rs and write rd. 14 BEQ reads rd,rs.
//   16 J reads/writes nothing. 31 NOP does nothing. Other opcodes are treated as NOP.
//  FSM:
//   FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch word into ibuf -> ISSUE.
//   ISSUE, END word: -> HALT; nothing issued.
//   ISSUE, J: pc<=jaddr -> FETCH; J is not issued.
//   ISSUE, hazard (any read reg has sb>0, R0 excepted): stay; stall_cnt+=1, saturating.
//   ISSUE, !ex_ready and no hazard: stay; stall_cnt unchanged.
//   ISSUE, otherwise: issue edge -> if_valid=1 next cycle, if_instr=ibuf, if_pc=pc; pc<=pc+1.
//    BEQ -> WAIT_BR; all other ops -> FETCH.
//   WAIT_BR: on br_done, pc<=br_taken ? br_target : pc (already pc+1) -> FETCH.
//   HALT: imem_req=0, if_valid=0, halted=1 until reset.
//  Scoreboard: 3-bit counter per register R1..R31; R0 is never marked.
//   On an issue edge of a writer, sb[rd]<=WB_LAT; this load overrides that edge's decrement.
//   All other nonzero counters decrement every edge.
//  Boundaries:
//   pc+1 wraps 0xFFFFFFFF->0.
//   br_done outside WAIT_BR is ignored.
//   Throughput is at most 1 issue per 2 cycles; there is no prefetch.
//   A J to its own address loops forever; this is legal and there is no watchdog.
// STRUCTURE
//  Package core_isa_pkg: opcode localparams (OP_ADD..OP_CMP, OP_BEQ=14, OP_J=16, OP_NOP=31),
//   NOP_WORD, END_WORD, field-slice functions, reads_rs/reads_rt/reads_rd/writes_rd functions.
//  Sub-module reg_scoreboard: mark/rd inputs, three read ports, hazard output.
//  FSM and PC stay in this module.
// TESTING
//  All scenarios use zero-wait imem (imem_valid with first req cycle).
//  1 Reset: rst_n low mid-FETCH -> imem_req=0, if_instr=0xF8000000, pc=0 immediately.
//  2 Back-to-back RAW: 0x10420001 (ADDI R1,R1,1) then 0x20C22000 (MLT R3,R1,R2):
//    MLT if_valid exactly 4 cycles after ADDI if_valid; stall_cnt=2.
//  3 Jump: 0x80000012 (J 18) at pc 14 -> never issued; next imem_addr=18.
//  4 Branch: 0x7046000F (BEQ R1,R3,15) at pc 10 -> WAIT_BR.
//    br_done&br_taken, target 15 -> imem_addr=15. Not taken -> imem_addr=11.
//  5 END: 0xFFFFFFFF fetched -> halted=1, no if_valid, imem_req=0 thereafter.
//  6 Backpressure: ex_ready=0 for 5 cycles on an independent ADDI -> held; stall_cnt unchanged;
//    issues the cycle after ex_ready rises.

Source files
------------

// File: rtl/core_isa_pkg.sv
// ISA constants and decode helpers for the 5-bit-opcode 32-bit core.
// Shared by the fetch/issue controller and its register scoreboard.
package core_isa_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_SUBI = 5'd3;
    localparam logic [4:0] OP_MLT  = 5'd4;
    localparam logic [4:0] OP_BEQ  = 5'd14;
    localparam logic [4:0] OP_J    = 5'd16;
    localparam logic [4:0] OP_CMP  = 5'd17;
    localparam logic [4:0] OP_NOP  = 5'd31;

    localparam logic [31:0] NOP_WORD = 32'hF800_0000;
    localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_WAIT_BR,
        S_HALT
    } fi_state_e;

    function automatic logic [4:0] f_op(input logic [31:0] w);
        return w[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[26:22];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[21:17];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[16:12];
    endfunction

    function automatic logic [31:0] f_jaddr(input logic [31:0] w);
        return {5'b0, w[26:0]};
    endfunction

    function automatic logic is_rtype(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MLT) || (op == OP_CMP);
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic reads_rs(input logic [4:0] op);
        return is_rtype(op) || is_imm(op) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_rt(input logic [4:0] op);
        return is_rtype(op);
    endfunction

    function automatic logic reads_rd(input logic [4:0] op);
        return op == OP_BEQ;
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return is_rtype(op) || is_imm(op);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-latency scoreboard: a register stays busy for WB_LAT edges
// after a writer issues. R0 is hardwired and never busy.
module reg_scoreboard #(
    parameter int WB_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mark,
    input  logic [4:0] mark_rd,
    input  logic [4:0] rd_a,
    input  logic       rd_a_en,
    input  logic [4:0] rd_b,
    input  logic       rd_b_en,
    input  logic [4:0] rd_c,
    input  logic       rd_c_en,
    output logic       hazard
);

    localparam logic [2:0] LAT = 3'(WB_LAT);

    logic [2:0]  cnt [1:31];
    logic [31:0] busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    // NOTE: these 31 counters are control state (not a data array), so they are
    // reset; a stale busy bit after reset would deadlock issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (mark && mark_rd == 5'(i))
                    cnt[i] <= LAT;
                else if (cnt[i] != 3'd0)
                    cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) busy[i] = (cnt[i] != 3'd0);
    end

    assign hazard = (rd_a_en && busy[rd_a]) || (rd_b_en && busy[rd_b]) || (rd_c_en && busy[rd_c]);

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer: owns the PC, fetches one word at a time, resolves J at
// fetch, parks on BEQ until EX resolves it, and interlocks RAW hazards.
module fetch_issue_ctrl
    import core_isa_pkg::*;
#(
    parameter int          WB_LAT   = 3,
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    input  logic               ex_ready,
    input  logic               br_done,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic               halted,
    output logic [STALL_W-1:0] stall_cnt
);

    fi_state_e    state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  ibuf;
    logic         req_q, req_n;
    logic         load_ibuf, issue, stall_inc, hazard;
    logic [4:0]   op;

    assign op = f_op(ibuf);

    reg_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .mark    (issue && writes_rd(op)),
        .mark_rd (f_rd(ibuf)),
        .rd_a    (f_rs(ibuf)),
        .rd_a_en (reads_rs(op)),
        .rd_b    (f_rt(ibuf)),
        .rd_b_en (reads_rt(op)),
        .rd_c    (f_rd(ibuf)),
        .rd_c_en (reads_rd(op)),
        .hazard  (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= PC_RESET;
            req_q <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            req_q <= req_n;
        end
    end

    // req_q gates imem_valid, so a response to a fetch abandoned by reset is dropped.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_n     = 1'b0;
        load_ibuf = 1'b0;
        issue     = 1'b0;
        stall_inc = 1'b0;
        case (state)
            S_FETCH: begin
                if (req_q && imem_valid) begin
                    load_ibuf = 1'b1;
                    state_n   = S_ISSUE;
                end else begin
                    req_n = 1'b1;
                end
            end
            S_ISSUE: begin
                if (ibuf == END_WORD) begin
                    state_n = S_HALT;
                end else if (op == OP_J) begin
                    pc_n    = f_jaddr(ibuf);
                    state_n = S_FETCH;
                    req_n   = 1'b1;
                end else if (hazard) begin
                    stall_inc = 1'b1;
                end else if (ex_ready) begin
                    issue = 1'b1;
                    pc_n  = pc + 32'd1;
                    if (op == OP_BEQ) begin
                        state_n = S_WAIT_BR;
                    end else begin
                        state_n = S_FETCH;
                        req_n   = 1'b1;
                    end
                end
            end
            S_WAIT_BR: begin
                if (br_done) begin
                    if (br_taken) pc_n = br_target;
                    state_n = S_FETCH;
                    req_n   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf      <= NOP_WORD;
            if_valid  <= 1'b0;
            if_instr  <= NOP_WORD;
            if_pc     <= '0;
            stall_cnt <= '0;
        end else begin
            if (load_ibuf) ibuf <= imem_rdata;
            if_valid <= issue;
            if_instr <= issue ? ibuf : NOP_WORD;
            if (issue) if_pc <= pc;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Scoreboard bench for fetch_issue_ctrl: directed programs in a zero-wait
// instruction memory, expected issues queued up front and popped by a monitor.
module tb_fetch_issue_ctrl;
    import core_isa_pkg::*;

    localparam logic [31:0] W_ADDI_R1 = 32'h1042_0001;
    localparam logic [31:0] W_MLT_R3  = 32'h20C2_2000;
    localparam logic [31:0] W_BEQ     = 32'h7046_000F;
    localparam logic [31:0] W_ADDI_R5 = 32'h114C_0001;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk, rst_n;
    logic        imem_req, imem_valid, ex_ready, br_done, br_taken;
    logic [31:0] imem_addr, imem_rdata, br_target;
    logic        if_valid, halted;
    logic [31:0] if_instr, if_pc;
    logic [15:0] stall_cnt;

    logic [31:0] mem [64];
    exp_t        exp_q [$];
    logic [31:0] fetch_log [$];
    logic [31:0] exp_fetch [$];
    int          issue_cyc [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    assign imem_rdata = mem[imem_addr[5:0]];
    assign imem_valid = imem_req;

    fetch_issue_ctrl #(.WB_LAT(3), .PC_RESET(32'h0), .STALL_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ex_ready   (ex_ready),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue monitor: every if_valid pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && if_valid) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_issue: got pc 0x%08h instr 0x%08h, expected no issue", if_pc, if_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_pc", if_pc, e.pc);
                check("issue_instr", if_instr, e.instr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req && imem_valid) fetch_log.push_back(imem_addr);
    end

    task automatic init_env();
        rst_n     = 1'b0;
        ex_ready  = 1'b1;
        br_done   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        for (int i = 0; i < 64; i++) mem[i] = END_WORD;
        exp_q.delete();
        fetch_log.delete();
        exp_fetch.delete();
        issue_cyc.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_issues(input string name, input int cnt, input int budget);
        int n = 0;
        while (issue_cyc.size() < cnt && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_issue_count"}, 32'(issue_cyc.size()), 32'(cnt));
    endtask

    task automatic pulse_br(input logic taken, input logic [31:0] target);
        @(negedge clk);
        #1;
        br_done = 1'b1;
        br_taken = taken;
        br_target = target;
        @(negedge clk);
        #1;
        br_done = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic check_fetch(input string name);
        check({name, "_fetch_count"}, 32'(fetch_log.size()), 32'(exp_fetch.size()));
        for (int i = 0; i < exp_fetch.size() && i < fetch_log.size(); i++)
            check({name, "_fetch_addr"}, fetch_log[i], exp_fetch[i]);
        check({name, "_leftover_issues"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int rise;

        // Reset state, then reset asserted in the middle of a fetch.
        init_env();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, NOP_WORD);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        mem[0] = NOP_WORD;
        push_exp(32'd0, NOP_WORD);
        release_reset();
        n = 0;
        while (!(imem_req && imem_addr == 32'd1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midfetch_addr", imem_addr, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_imem_req", 32'(imem_req), 32'd0);
        check("async_rst_pc", imem_addr, 32'd0);
        check("async_rst_if_instr", if_instr, NOP_WORD);
        check("nop_issued_before_rst", 32'(exp_q.size()), 32'd0);

        // Back-to-back RAW: MLT waits on R1 written by ADDI.
        init_env();
        mem[0] = W_ADDI_R1;
        mem[1] = W_MLT_R3;
        push_exp(32'd0, W_ADDI_R1);
        push_exp(32'd1, W_MLT_R3);
        exp_fetch = '{32'd0, 32'd1, 32'd2};
        release_reset();
        wait_halt("raw", 100);
        if (issue_cyc.size() >= 2)
            check("raw_issue_gap", 32'(issue_cyc[1] - issue_cyc[0]), 32'd4);
        check("raw_stall_cnt", 32'(stall_cnt), 32'd2);
        repeat (5) @(negedge clk);
        #1;
        check("end_imem_req", 32'(imem_req), 32'd0);
        check("end_halted_sticky", 32'(halted), 32'd1);
        check_fetch("raw");

        // Jump resolved at fetch, never issued.
        init_env();
        mem[0]  = 32'h8000_000E;
        mem[14] = 32'h8000_0012;
        exp_fetch = '{32'd0, 32'd14, 32'd18};
        release_reset();
        wait_halt("jump", 100);
        check_fetch("jump");

        // BEQ taken; a stray br_done before the BEQ must be ignored.
        init_env();
        mem[0]  = 32'h8000_000A;
        mem[10] = W_BEQ;
        push_exp(32'd10, W_BEQ);
        exp_fetch = '{32'd0, 32'd10, 32'd15};
        release_reset();
        pulse_br(1'b1, 32'd40);
        wait_issues("beq_t", 1, 100);
        repeat (3) @(negedge clk);
        #1;
        check("wait_br_imem_req", 32'(imem_req), 32'd0);
        pulse_br(1'b1, 32'd15);
        wait_halt("beq_t", 100);
        check_fetch("beq_t");

        // BEQ not taken falls through to pc+1.
        init_env();
        mem[0]  = 32'h8000_000A;
        mem[10] = W_BEQ;
        push_exp(32'd10, W_BEQ);
        exp_fetch = '{32'd0, 32'd10, 32'd11};
        release_reset();
        wait_issues("beq_nt", 1, 100);
        pulse_br(1'b0, 32'd15);
        wait_halt("beq_nt", 100);
        check_fetch("beq_nt");

        // PC wraps from 0xFFFFFFFF to 0.
        init_env();
        mem[0]  = W_BEQ;
        mem[63] = W_ADDI_R5;
        push_exp(32'd0, W_BEQ);
        push_exp(32'hFFFF_FFFF, W_ADDI_R5);
        push_exp(32'd0, W_BEQ);
        exp_fetch = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
        release_reset();
        wait_issues("wrap_a", 1, 100);
        pulse_br(1'b1, 32'hFFFF_FFFF);
        wait_issues("wrap_b", 3, 100);
        pulse_br(1'b0, 32'd32);
        wait_halt("wrap", 100);
        check_fetch("wrap");

        // Backpressure on an independent ADDI.
        init_env();
        mem[0] = W_ADDI_R5;
        push_exp(32'd0, W_ADDI_R5);
        exp_fetch = '{32'd0, 32'd1};
        ex_ready = 1'b0;
        release_reset();
        repeat (7) @(negedge clk);
        #1;
        check("bp_held", 32'(issue_cyc.size()), 32'd0);
        check("bp_stall_cnt", 32'(stall_cnt), 32'd0);
        ex_ready = 1'b1;
        rise = cyc;
        wait_issues("bp", 1, 20);
        if (issue_cyc.size() >= 1)
            check("bp_issue_cycle", 32'(issue_cyc[0]), 32'(rise + 1));
        wait_halt("bp", 100);
        check("bp_stall_cnt_end", 32'(stall_cnt), 32'd0);
        check_fetch("bp");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
